vga_text_avl_writer: RTL and testbench

- Avalon-MM master that drives the VGA text-mode VRAM slave over its slave port (600 VRAM words at 0x000-0x257, control register at 0x258).
- Accepts simple drawing commands on a valid/ready port: put one glyph at (row, col), fill the whole screen with one glyph, or set the colour register.
- Converts each command into correctly byte-enabled Avalon write transfers and honours waitrequest.
- Sits between the CPU-side command logic and the text-mode display IP. Software and hardware use the same VRAM layout.

---
 rtl/vga_text_avl_writer.sv | 190 +++++++++++++++++++
 tb/tb_vga_text_avl_writer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_avl_writer.sv
// VGA text-mode VRAM writer: turns PUT / FILL / COLOR commands into
// byte-enabled Avalon-MM write transfers towards the text-mode display slave.
`timescale 1ns/1ps
module vga_text_avl_writer #(
  parameter int COLS      = 80,
  parameter int ROWS      = 30,
  parameter int CTRL_ADDR = 600
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_OP,
  input  logic [4:0]  CMD_ROW,
  input  logic [6:0]  CMD_COL,
  input  logic [6:0]  CMD_CODE,
  input  logic        CMD_INV,
  input  logic [11:0] CMD_FGD,
  input  logic [11:0] CMD_BKG,
  output logic        AVM_CS,
  output logic        AVM_WRITE,
  output logic [9:0]  AVM_ADDR,
  output logic [3:0]  AVM_BYTE_EN,
  output logic [31:0] AVM_WRITEDATA,
  input  logic        AVM_WAITREQUEST,
  output logic        DONE,
  output logic        ERR
);

  localparam logic [1:0] OP_PUT   = 2'd0;
  localparam logic [1:0] OP_FILL  = 2'd1;
  localparam logic [1:0] OP_COLOR = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  // Last VRAM word: four glyph bytes are packed per 32-bit word.
  localparam logic [9:0] LAST_ADDR = 10'((ROWS * COLS) / 4 - 1);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_WRITE, S_NEXT, S_FIN} state_t;

  state_t      state_q;
  logic        ready_q;
  logic        cs_q;
  logic        write_q;
  logic [9:0]  addr_q;
  logic [3:0]  be_q;
  logic [31:0] data_q;
  logic        done_q;
  logic        err_q;

  // Command fields captured at accept; later input changes do not matter.
  logic [1:0]  op_q;
  logic [4:0]  row_q;
  logic [6:0]  col_q;
  logic [7:0]  glyph_q;
  logic [11:0] fgd_q;
  logic [11:0] bkg_q;

  logic [11:0] idx_d;
  logic [1:0]  lane_d;
  logic        bad_d;

  // Control register layout: {7'b0, FGD RGB, BKG RGB, 1'b0}.
  function automatic logic [31:0] color_word(input logic [11:0] fgd,
                                             input logic [11:0] bkg);
    return {7'd0, fgd, bkg, 1'b0};
  endfunction

  // Place one glyph byte in the selected byte lane, other lanes zero.
  function automatic logic [31:0] lane_word(input logic [7:0] glyph,
                                            input logic [1:0] lane);
    return 32'(glyph) << {lane, 3'b000};
  endfunction

  // Linear glyph index and command validity from the latched fields.
  always_comb begin
    idx_d  = 12'(row_q) * 12'(COLS) + 12'(col_q);
    lane_d = idx_d[1:0];
    bad_d  = (op_q == OP_RSVD) ||
             ((op_q == OP_PUT) && ((row_q >= 5'(ROWS)) || (col_q >= 7'(COLS))));
  end

  // Command FSM with all Avalon and status outputs registered.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      cs_q    <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      op_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      glyph_q <= '0;
      fgd_q   <= '0;
      bkg_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (CMD_VALID) begin
            op_q    <= CMD_OP;
            row_q   <= CMD_ROW;
            col_q   <= CMD_COL;
            glyph_q <= {CMD_INV, CMD_CODE};
            fgd_q   <= CMD_FGD;
            bkg_q   <= CMD_BKG;
            ready_q <= 1'b0;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          if (bad_d) begin
            err_q   <= 1'b1;
            state_q <= S_FIN;
          end else begin
            case (op_q)
              OP_PUT: begin
                addr_q <= idx_d[11:2];
                be_q   <= 4'b0001 << lane_d;
                data_q <= lane_word(glyph_q, lane_d);
              end
              OP_FILL: begin
                addr_q <= '0;
                be_q   <= 4'b1111;
                data_q <= {4{glyph_q}};
              end
              default: begin
                addr_q <= 10'(CTRL_ADDR);
                be_q   <= 4'b1111;
                data_q <= color_word(fgd_q, bkg_q);
              end
            endcase
            cs_q    <= 1'b1;
            write_q <= 1'b1;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          // Address, enables and data stay put until the slave stops stalling.
          if (!AVM_WAITREQUEST) begin
            cs_q    <= 1'b0;
            write_q <= 1'b0;
            if (op_q == OP_FILL) begin
              state_q <= S_NEXT;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end
          end
        end
        S_NEXT: begin
          if (addr_q == LAST_ADDR) begin
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            addr_q  <= addr_q + 10'd1;
            cs_q    <= 1'b1;
            write_q <= 1'b1;
            state_q <= S_WRITE;
          end
        end
        S_FIN: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          cs_q    <= 1'b0;
          write_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign CMD_READY     = ready_q;
  assign AVM_CS        = cs_q;
  assign AVM_WRITE     = write_q;
  assign AVM_ADDR      = addr_q;
  assign AVM_BYTE_EN   = be_q;
  assign AVM_WRITEDATA = data_q;
  assign DONE          = done_q;
  assign ERR           = err_q;

endmodule

// File: tb/tb_vga_text_avl_writer.sv
// Bench for vga_text_avl_writer: command table plus hand-written stall,
// fill and reset sequences; completed writes are checked against a queue.
`timescale 1ns/1ps
module tb_vga_text_avl_writer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [1:0]  CMD_OP;
  logic [4:0]  CMD_ROW;
  logic [6:0]  CMD_COL;
  logic [6:0]  CMD_CODE;
  logic        CMD_INV;
  logic [11:0] CMD_FGD;
  logic [11:0] CMD_BKG;
  logic        AVM_CS;
  logic        AVM_WRITE;
  logic [9:0]  AVM_ADDR;
  logic [3:0]  AVM_BYTE_EN;
  logic [31:0] AVM_WRITEDATA;
  logic        AVM_WAITREQUEST;
  logic        DONE;
  logic        ERR;

  vga_text_avl_writer dut (
    .CLK(CLK), .RESET(RESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_ROW(CMD_ROW), .CMD_COL(CMD_COL), .CMD_CODE(CMD_CODE),
    .CMD_INV(CMD_INV), .CMD_FGD(CMD_FGD), .CMD_BKG(CMD_BKG),
    .AVM_CS(AVM_CS), .AVM_WRITE(AVM_WRITE), .AVM_ADDR(AVM_ADDR),
    .AVM_BYTE_EN(AVM_BYTE_EN), .AVM_WRITEDATA(AVM_WRITEDATA),
    .AVM_WAITREQUEST(AVM_WAITREQUEST), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [9:0]  a;
    logic [3:0]  b;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  row;
    logic [6:0]  col;
    logic [6:0]  code;
    logic        inv;
    logic [11:0] fgd;
    logic [11:0] bkg;
    logic [9:0]  ea;
    logic [3:0]  eb;
    logic [31:0] ed;
    logic        eerr;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[9];
  int   total = 0;
  int   bad = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Completed transfers are popped from the expected queue and compared.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (DONE) done_cnt++;
      if (DONE && ERR) chk("done_err_exclusive", 32'(ERR), 32'd0);
      if (AVM_WRITE && !AVM_WAITREQUEST) begin
        wr_t e;
        wr_cnt++;
        chk("wr_cs", 32'(AVM_CS), 32'd1);
        chk("wr_ready_low", 32'(CMD_READY), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", 32'(AVM_ADDR), 32'h3ff);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(AVM_ADDR), 32'(e.a));
          chk("wr_be", 32'(AVM_BYTE_EN), 32'(e.b));
          chk("wr_data", AVM_WRITEDATA, e.d);
        end
      end
    end
  end

  task automatic do_cmd(input logic [1:0] op, input logic [4:0] row, input logic [6:0] col,
                        input logic [6:0] code, input logic inv,
                        input logic [11:0] fgd, input logic [11:0] bkg);
    int n = 0;
    while (!CMD_READY && n < 50) begin
      tick();
      n++;
    end
    chk("ready_before_cmd", 32'(CMD_READY), 32'd1);
    CMD_OP = op; CMD_ROW = row; CMD_COL = col; CMD_CODE = code;
    CMD_INV = inv; CMD_FGD = fgd; CMD_BKG = bkg;
    CMD_VALID = 1'b1;
    tick();
    CMD_VALID = 1'b0;
    chk("ready_drop_after_accept", 32'(CMD_READY), 32'd0);
    // Scramble the fields: the running command must not notice.
    CMD_OP = 2'($urandom); CMD_ROW = 5'($urandom); CMD_COL = 7'($urandom);
    CMD_CODE = 7'($urandom); CMD_INV = 1'($urandom);
    CMD_FGD = 12'($urandom); CMD_BKG = 12'($urandom);
  endtask

  task automatic wait_end(input int bound, output bit gd, output bit ge);
    gd = 1'b0;
    ge = 1'b0;
    for (int i = 0; i < bound && !gd && !ge; i++) begin
      if (DONE) gd = 1'b1;
      if (ERR) ge = 1'b1;
      if (!gd && !ge) tick();
    end
    chk("end_within_bound", 32'(gd | ge), 32'd1);
    tick();
    chk("pulse_one_cycle", 32'({DONE, ERR}), 32'd0);
    chk("ready_after_end", 32'(CMD_READY), 32'd1);
  endtask

  initial begin
    bit gd, ge;
    int w0, d0, n;
    logic [31:0] hold_d;
    logic [9:0]  hold_a;

    vecs[0] = '{2'd0, 5'd1,  7'd5,  7'h41, 1'b1, 12'h0,   12'h0,   10'd21,  4'b0010, 32'h0000C100, 1'b0};
    vecs[1] = '{2'd0, 5'd29, 7'd79, 7'h7F, 1'b0, 12'h0,   12'h0,   10'd599, 4'b1000, 32'h7F000000, 1'b0};
    vecs[2] = '{2'd0, 5'd0,  7'd0,  7'h55, 1'b0, 12'h0,   12'h0,   10'd0,   4'b0001, 32'h00000055, 1'b0};
    vecs[3] = '{2'd0, 5'd0,  7'd2,  7'h3A, 1'b1, 12'h0,   12'h0,   10'd0,   4'b0100, 32'h00BA0000, 1'b0};
    vecs[4] = '{2'd0, 5'd12, 7'd3,  7'h01, 1'b0, 12'h0,   12'h0,   10'd240, 4'b1000, 32'h01000000, 1'b0};
    vecs[5] = '{2'd2, 5'd0,  7'd0,  7'h00, 1'b0, 12'hABC, 12'h123, 10'd600, 4'b1111, 32'h01578246, 1'b0};
    vecs[6] = '{2'd0, 5'd30, 7'd0,  7'h41, 1'b0, 12'h0,   12'h0,   10'd0,   4'b0000, 32'h0,        1'b1};
    vecs[7] = '{2'd3, 5'd0,  7'd0,  7'h41, 1'b0, 12'h0,   12'h0,   10'd0,   4'b0000, 32'h0,        1'b1};
    vecs[8] = '{2'd0, 5'd0,  7'd80, 7'h41, 1'b0, 12'h0,   12'h0,   10'd0,   4'b0000, 32'h0,        1'b1};

    RESET = 1'b1; CMD_VALID = 1'b0; CMD_OP = '0; CMD_ROW = '0; CMD_COL = '0;
    CMD_CODE = '0; CMD_INV = 1'b0; CMD_FGD = '0; CMD_BKG = '0; AVM_WAITREQUEST = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(CMD_READY), 32'd1);
    chk("rst_write", 32'({AVM_CS, AVM_WRITE}), 32'd0);
    chk("rst_addr", 32'(AVM_ADDR), 32'd0);
    chk("rst_be", 32'(AVM_BYTE_EN), 32'd0);
    chk("rst_data", AVM_WRITEDATA, 32'd0);
    chk("rst_done_err", 32'({DONE, ERR}), 32'd0);
    RESET = 1'b0;
    tick();

    // Single-transfer and rejected commands.
    foreach (vecs[i]) begin
      w0 = wr_cnt;
      if (!vecs[i].eerr) exp_q.push_back('{vecs[i].ea, vecs[i].eb, vecs[i].ed});
      do_cmd(vecs[i].op, vecs[i].row, vecs[i].col, vecs[i].code, vecs[i].inv,
             vecs[i].fgd, vecs[i].bkg);
      wait_end(20, gd, ge);
      chk($sformatf("vec%0d_done", i), 32'(gd), 32'(!vecs[i].eerr));
      chk($sformatf("vec%0d_err", i), 32'(ge), 32'(vecs[i].eerr));
      chk($sformatf("vec%0d_nwrites", i), 32'(wr_cnt - w0), vecs[i].eerr ? 32'd0 : 32'd1);
    end

    // COLOR with the slave stalling for three cycles.
    exp_q.push_back('{10'd600, 4'b1111, 32'h01E00006});
    AVM_WAITREQUEST = 1'b1;
    do_cmd(2'd2, 5'd0, 7'd0, 7'd0, 1'b0, 12'hF00, 12'h003);
    n = 0;
    while (!AVM_WRITE && n < 10) begin
      tick();
      n++;
    end
    chk("stall_write_seen", 32'(AVM_WRITE), 32'd1);
    hold_a = AVM_ADDR;
    hold_d = AVM_WRITEDATA;
    chk("stall_addr", 32'(hold_a), 32'd600);
    chk("stall_data", hold_d, 32'h01E00006);
    repeat (3) begin
      tick();
      chk("stall_write_held", 32'(AVM_WRITE), 32'd1);
      chk("stall_addr_held", 32'(AVM_ADDR), 32'(hold_a));
      chk("stall_data_held", AVM_WRITEDATA, hold_d);
      chk("stall_no_done", 32'(DONE), 32'd0);
    end
    AVM_WAITREQUEST = 1'b0;
    tick();
    chk("stall_done", 32'(DONE), 32'd1);
    chk("stall_write_off", 32'(AVM_WRITE), 32'd0);
    tick();
    chk("stall_ready", 32'(CMD_READY), 32'd1);

    // Full-screen fill: 600 ascending writes, one DONE.
    for (int a = 0; a < 600; a++) exp_q.push_back('{10'(a), 4'b1111, 32'h20202020});
    w0 = wr_cnt;
    d0 = done_cnt;
    do_cmd(2'd1, 5'd0, 7'd0, 7'h20, 1'b0, 12'h0, 12'h0);
    wait_end(2000, gd, ge);
    chk("fill_done", 32'(gd), 32'd1);
    chk("fill_nwrites", 32'(wr_cnt - w0), 32'd600);
    chk("fill_done_count", 32'(done_cnt - d0), 32'd1);
    chk("fill_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a fill.
    for (int a = 0; a < 600; a++) exp_q.push_back('{10'(a), 4'b1111, 32'h41414141});
    w0 = wr_cnt;
    do_cmd(2'd1, 5'd0, 7'd0, 7'h41, 1'b0, 12'h0, 12'h0);
    n = 0;
    while (wr_cnt - w0 < 10 && n < 100) begin
      tick();
      n++;
    end
    chk("rstmid_reached_10", 32'(wr_cnt - w0 >= 10), 32'd1);
    d0 = done_cnt;
    RESET = 1'b1;
    tick();
    chk("rstmid_write_off", 32'(AVM_WRITE), 32'd0);
    chk("rstmid_ready", 32'(CMD_READY), 32'd1);
    RESET = 1'b0;
    exp_q.delete();
    w0 = wr_cnt;
    repeat (5) begin
      chk("rstmid_no_pulse", 32'({DONE, ERR}), 32'd0);
      tick();
    end
    chk("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rstmid_no_writes", 32'(wr_cnt - w0), 32'd0);
    exp_q.push_back('{10'd21, 4'b0010, 32'h0000C100});
    do_cmd(2'd0, 5'd1, 7'd5, 7'h41, 1'b1, 12'h0, 12'h0);
    wait_end(20, gd, ge);
    chk("after_rst_put_done", 32'(gd), 32'd1);
    chk("after_rst_put_writes", 32'(wr_cnt - w0), 32'd1);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
